// File: rtl/oled_arb_pkg.sv
// ---------------------------------------------------------------------------
// oled_arb_pkg
//   Shared types and constants for the OLED message arbiter slice.
//   DATA_W    : width of one byte on the oledControl port
//   N_REQ_MAX : largest supported requester count
//   IDX_W     : width of a requester index (sized for N_REQ_MAX)
//   state_t   : arbiter FSM states (ARB, SEND, RELEASE, HOLD)
// ---------------------------------------------------------------------------
package oled_arb_pkg;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned N_REQ_MAX = 8;
    localparam int unsigned IDX_W     = $clog2(N_REQ_MAX);

    typedef enum logic [1:0] {
        ARB     = 2'd0,
        SEND    = 2'd1,
        RELEASE = 2'd2,
        HOLD    = 2'd3
    } state_t;

endpackage

// File: rtl/oled_rr_pick.sv
// ---------------------------------------------------------------------------
// oled_rr_pick
//   Combinational round-robin picker: returns the first set request bit
//   found scanning upward from ptr_i, wrapping N_REQ-1 -> 0.
// Ports
//   req_i    in  N_REQ  request vector
//   ptr_i    in  IDX_W  scan start index (must be < N_REQ)
//   onehot_o out N_REQ  one-hot winner, zero when no request
//   idx_o    out IDX_W  winner index, zero when no request
//   any_o    out 1      at least one request present
// ---------------------------------------------------------------------------
module oled_rr_pick
    import oled_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 4
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N_REQ-1:0] onehot_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    always_comb begin
        int unsigned      c;
        logic [N_REQ-1:0] sh;
        c        = 0;
        sh       = '0;
        onehot_o = '0;
        idx_o    = '0;
        any_o    = 1'b0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            c = 32'(ptr_i) + k;
            if (c >= N_REQ) begin
                c = c - N_REQ;
            end
            sh = req_i >> c;
            if (!any_o && sh[0]) begin
                any_o    = 1'b1;
                idx_o    = c[IDX_W-1:0];
                onehot_o = N_REQ'(1) << c;
            end
        end
    end

endmodule

// File: rtl/oled_msg_arbiter.sv
// ---------------------------------------------------------------------------
// oled_msg_arbiter
//   Round-robin arbiter sharing the oledControl byte port among N_REQ text
//   sources. Whole messages are granted: the owner keeps the port from its
//   first byte through the byte flagged req_last. 4-phase handshake toward
//   oledControl (valid up -> done up -> valid down -> done down).
// Ports
//   clock, reset        100MHz clock, synchronous active-high reset
//   req_valid/req_last  per-requester byte pending / byte ends message
//   req_data            byte of requester i at [8*i+7:8*i]
//   req_ready           1-cycle pulse when requester i's byte is fully sent
//   grant, busy         one-hot current owner; busy = grant != 0
//   timeout_err         1-cycle pulse on forced release of an idle owner
//   sendData/sendDataValid/sendDone  oledControl byte port
// Configuration
//   OLED_ARB_TIMEOUT_EN : when defined, an owner idle in HOLD for
//   TIMEOUT_CYCLES cycles is forcibly released; otherwise HOLD waits forever.
// ---------------------------------------------------------------------------
module oled_msg_arbiter
    import oled_arb_pkg::*;
#(
    parameter int unsigned N_REQ          = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [DATA_W*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]        req_last,
    output logic [N_REQ-1:0]        req_ready,
    output logic [N_REQ-1:0]        grant,
    output logic                    busy,
    output logic                    timeout_err,
    output logic [DATA_W-1:0]       sendData,
    output logic                    sendDataValid,
    input  logic                    sendDone
);

    state_t                  state_q, state_d;
    logic [N_REQ-1:0]        grant_q, grant_d;
    logic [N_REQ-1:0]        ready_q, ready_d;
    logic [IDX_W-1:0]        owner_q, owner_d;
    logic [IDX_W-1:0]        rr_q, rr_d;
    logic [DATA_W-1:0]       data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    last_q, last_d;
    logic                    msg_end_q, msg_end_d;
    logic                    busy_q;

    logic [N_REQ-1:0]        pick_onehot;
    logic [IDX_W-1:0]        pick_idx;
    logic                    pick_any;
    logic [IDX_W-1:0]        lidx;
    logic [IDX_W-1:0]        next_ptr;
    logic [DATA_W*N_REQ-1:0] data_vec;
    logic [N_REQ-1:0]        last_vec;
    logic                    owner_valid;

`ifdef OLED_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tmo_q, tmo_d;
`endif

    oled_rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req_i    (req_valid),
        .ptr_i    (rr_q),
        .onehot_o (pick_onehot),
        .idx_o    (pick_idx),
        .any_o    (pick_any)
    );

    // Launch source: round-robin winner in ARB, the locked owner in HOLD.
    assign lidx        = (state_q == HOLD) ? owner_q : pick_idx;
    assign data_vec    = req_data >> (DATA_W * 32'(lidx));
    assign last_vec    = req_last >> lidx;
    assign owner_valid = |(req_valid & grant_q);
    assign next_ptr    = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + IDX_W'(1);

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        rr_d      = rr_q;
        data_d    = data_q;
        valid_d   = valid_q;
        last_d    = last_q;
        msg_end_d = msg_end_q;
        ready_d   = '0;
`ifdef OLED_ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        tmo_d     = 1'b0;
`endif
        case (state_q)
            ARB: begin
                if (pick_any && !sendDone) begin
                    grant_d = pick_onehot;
                    owner_d = pick_idx;
                    data_d  = data_vec[DATA_W-1:0];
                    last_d  = last_vec[0];
                    valid_d = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (sendDone) begin
                    valid_d   = 1'b0;
                    ready_d   = grant_q;
                    msg_end_d = last_q;
                    state_d   = RELEASE;
                end
            end
            RELEASE: begin
                if (!sendDone) begin
                    if (msg_end_q) begin
                        grant_d = '0;
                        rr_d    = next_ptr;
                        state_d = ARB;
                    end else begin
`ifdef OLED_ARB_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (owner_valid && !sendDone) begin
                    data_d  = data_vec[DATA_W-1:0];
                    last_d  = last_vec[0];
                    valid_d = 1'b1;
                    state_d = SEND;
                end
`ifdef OLED_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    tmo_d   = 1'b1;
                    grant_d = '0;
                    rr_d    = next_ptr;
                    state_d = ARB;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ARB;
            grant_q   <= '0;
            owner_q   <= '0;
            rr_q      <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            msg_end_q <= 1'b0;
            ready_q   <= '0;
            busy_q    <= 1'b0;
`ifdef OLED_ARB_TIMEOUT_EN
            cnt_q     <= '0;
            tmo_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            owner_q   <= owner_d;
            rr_q      <= rr_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            msg_end_q <= msg_end_d;
            ready_q   <= ready_d;
            busy_q    <= |grant_d;
`ifdef OLED_ARB_TIMEOUT_EN
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
`endif
        end
    end

    assign sendData      = data_q;
    assign sendDataValid = valid_q;
    assign req_ready     = ready_q;
    assign grant         = grant_q;
    assign busy          = busy_q;
`ifdef OLED_ARB_TIMEOUT_EN
    assign timeout_err   = tmo_q;
`else
    // No watchdog in this build: HOLD waits for the owner indefinitely.
    assign timeout_err   = (TIMEOUT_CYCLES == 0) && 1'b0;
`endif

endmodule

// File: tb/tb_oled_msg_arbiter.sv
// ---------------------------------------------------------------------------
// tb_oled_msg_arbiter
//   Directed bench for oled_msg_arbiter (N_REQ=4, TIMEOUT_CYCLES=16).
//   Requesters are byte queues; oledControl is a small 4-phase responder.
//   Define OLED_ARB_TIMEOUT_EN for both bench and RTL to exercise the watchdog.
// ---------------------------------------------------------------------------
module tb_oled_msg_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic [3:0]  grant;
    logic        busy;
    logic        timeout_err;
    logic [7:0]  sendData;
    logic        sendDataValid;
    logic        sendDone;

    int checks   = 0;
    int failures = 0;

    logic [8:0]  q [4][$];       // {last, data} per requester
    logic [11:0] sent [$];       // {grant, sendData} at each launch
    int          ready_cnt [4];
    bit          auto_done;
    int          dly;
    bit          prev_valid;
    bit          tmo_seen;
    int          tmo_tick;
    int          tick_no;

    oled_msg_arbiter #(.N_REQ(4), .TIMEOUT_CYCLES(16)) dut (
        .clock         (clock),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .grant         (grant),
        .busy          (busy),
        .timeout_err   (timeout_err),
        .sendData      (sendData),
        .sendDataValid (sendDataValid),
        .sendDone      (sendDone)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_reqs();
        logic [8:0] e;
        for (int i = 0; i < 4; i++) begin
            if (q[i].size() > 0) begin
                e = q[i][0];
                req_valid[i]       = 1'b1;
                req_data[8*i +: 8] = e[7:0];
                req_last[i]        = e[8];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_last[i]        = 1'b0;
            end
        end
    endtask

    task automatic push(input int i, input logic last, input logic [7:0] d);
        q[i].push_back({last, d});
        drive_reqs();
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        tick_no++;
        if (sendDataValid && !prev_valid) sent.push_back({grant, sendData});
        prev_valid = sendDataValid;
        if (timeout_err && !tmo_seen) begin
            tmo_seen = 1'b1;
            tmo_tick = tick_no;
        end
        for (int i = 0; i < 4; i++) begin
            if (req_ready[i]) begin
                ready_cnt[i]++;
                if (q[i].size() > 0) void'(q[i].pop_front());
            end
        end
        if (auto_done) begin
            if (sendDataValid && !sendDone) begin
                if (dly == 1) begin
                    sendDone = 1'b1;
                    dly      = 0;
                end else begin
                    dly++;
                end
            end else if (!sendDataValid && sendDone) begin
                sendDone = 1'b0;
            end
        end
        drive_reqs();
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        sendDone  = 1'b0;
        auto_done = 1'b1;
        dly       = 0;
        for (int i = 0; i < 4; i++) begin
            q[i].delete();
            ready_cnt[i] = 0;
        end
        sent.delete();
        drive_reqs();
        tick();
        tick();
        reset      = 1'b0;
        prev_valid = 1'b0;
        tmo_seen   = 1'b0;
        sent.delete();
    endtask

    task automatic wait_ready(input string tag, input int i, input int n);
        for (int c = 0; c < 300 && ready_cnt[i] < n; c++) tick();
        check(tag, ready_cnt[i], n);
    endtask

    task automatic wait_idle(input string tag);
        bit idle;
        idle = 1'b0;
        for (int c = 0; c < 500 && !idle; c++) begin
            tick();
            idle = (q[0].size() == 0) && (q[1].size() == 0) && (q[2].size() == 0) &&
                   (q[3].size() == 0) && (grant == 4'b0) && !sendDataValid && !sendDone;
        end
        check(tag, {31'b0, idle}, 32'd1);
    endtask

    initial begin
        int t0;
        tick_no   = 0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;

        // Reset state
        do_reset();
        check("rst_sendData", sendData, 8'h00);
        check("rst_valid", sendDataValid, 1'b0);
        check("rst_ready", req_ready, 4'b0000);
        check("rst_grant", grant, 4'b0000);
        check("rst_busy", busy, 1'b0);
        check("rst_tmo", timeout_err, 1'b0);

        // 1: req0 sends "abc"
        push(0, 1'b0, 8'h61);
        push(0, 1'b0, 8'h62);
        push(0, 1'b1, 8'h63);
        tick();
        check("t1_lat_valid", sendDataValid, 1'b1);
        check("t1_lat_data", sendData, 8'h61);
        check("t1_lat_grant", grant, 4'b0001);
        check("t1_lat_busy", busy, 1'b1);
        wait_idle("t1_idle");
        check("t1_ready0", ready_cnt[0], 3);
        check("t1_count", sent.size(), 3);
        check("t1_b0", sent[0], 12'h161);
        check("t1_b1", sent[1], 12'h162);
        check("t1_b2", sent[2], 12'h163);
        check("t1_grant_end", grant, 4'b0000);
        check("t1_busy_end", busy, 1'b0);

        // 2: req0 and req1 together, then rr_ptr=2 favours req3 over req0
        do_reset();
        push(0, 1'b0, 8'h10);
        push(0, 1'b1, 8'h11);
        push(1, 1'b0, 8'h20);
        push(1, 1'b1, 8'h21);
        wait_idle("t2_idle");
        check("t2_count", sent.size(), 4);
        check("t2_b0", sent[0], 12'h110);
        check("t2_b1", sent[1], 12'h111);
        check("t2_b2", sent[2], 12'h220);
        check("t2_b3", sent[3], 12'h221);
        sent.delete();
        push(0, 1'b1, 8'h50);
        push(3, 1'b1, 8'h53);
        wait_idle("t2_rr_idle");
        check("t2_rr_first", sent[0], 12'h853);
        check("t2_rr_second", sent[1], 12'h150);

        // 3: req1 waits while req0 sits in HOLD between bytes
        do_reset();
        push(0, 1'b0, 8'h30);
        push(1, 1'b1, 8'h40);
        wait_ready("t3_ready0", 0, 1);
        repeat (5) tick();
        check("t3_hold_grant", grant, 4'b0001);
        check("t3_hold_valid", sendDataValid, 1'b0);
        check("t3_hold_busy", busy, 1'b1);
        push(0, 1'b1, 8'h31);
        wait_idle("t3_idle");
        check("t3_count", sent.size(), 3);
        check("t3_b0", sent[0], 12'h130);
        check("t3_b1", sent[1], 12'h131);
        check("t3_b2", sent[2], 12'h240);

        // 4: sendDone held high in ARB blocks the launch
        do_reset();
        auto_done = 1'b0;
        sendDone  = 1'b1;
        push(2, 1'b1, 8'h55);
        repeat (3) tick();
        check("t4_blk_valid", sendDataValid, 1'b0);
        check("t4_blk_grant", grant, 4'b0000);
        sendDone  = 1'b0;
        auto_done = 1'b1;
        tick();
        check("t4_go_valid", sendDataValid, 1'b1);
        check("t4_go_grant", grant, 4'b0100);
        check("t4_go_data", sendData, 8'h55);
        wait_idle("t4_idle");
        check("t4_ready2", ready_cnt[2], 1);

        // 5: reset during SEND
        do_reset();
        auto_done = 1'b0;
        push(1, 1'b0, 8'h77);
        tick();
        check("t5_in_send", sendDataValid, 1'b1);
        repeat (2) tick();
        reset = 1'b1;
        tick();
        check("t5_valid", sendDataValid, 1'b0);
        check("t5_grant", grant, 4'b0000);
        check("t5_busy", busy, 1'b0);
        check("t5_ready", req_ready, 4'b0000);
        check("t5_no_pulse", ready_cnt[1], 0);

        // 6: owner stalls in HOLD with req1 waiting
        do_reset();
        push(0, 1'b0, 8'h01);
        push(1, 1'b1, 8'h02);
        wait_ready("t6_ready0", 0, 1);
        t0 = tick_no;
`ifdef OLED_ARB_TIMEOUT_EN
        for (int n = 0; n < 40 && !tmo_seen; n++) tick();
        check("t6_tmo_seen", {31'b0, tmo_seen}, 32'd1);
        check("t6_tmo_cycles", tmo_tick - t0, 17);
        check("t6_tmo_grant", grant, 4'b0000);
        tick();
        check("t6_tmo_pulse", timeout_err, 1'b0);
        check("t6_req1_grant", grant, 4'b0010);
        wait_idle("t6_idle");
        check("t6_count", sent.size(), 2);
        check("t6_b0", sent[0], 12'h101);
        check("t6_b1", sent[1], 12'h202);
`else
        repeat (40) tick();
        check("t6_hold_grant", grant, 4'b0001);
        check("t6_no_tmo", {31'b0, tmo_seen}, 32'd0);
        check("t6_hold_valid", sendDataValid, 1'b0);
        check("t6_elapsed", tick_no - t0, 40);
        push(0, 1'b1, 8'h03);
        wait_idle("t6_idle");
        check("t6_count", sent.size(), 3);
        check("t6_b0", sent[0], 12'h101);
        check("t6_b1", sent[1], 12'h103);
        check("t6_b2", sent[2], 12'h202);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
